// File: rtl/commit_trace_buffer.sv
// Multi-lane retire-trace capture FIFO: compacts up to RET_W retiring lanes per cycle
// into a DEPTH-entry queue drained one entry per cycle over valid/ready.
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int RET_W = 2,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [RET_W-1:0]                  ret_valid_i,
  input  logic [RET_W-1:0][XLEN-1:0]        ret_pc_i,
  input  logic [RET_W-1:0][XLEN-1:0]        ret_instr_i,
  input  logic [RET_W-1:0][4:0]             ret_rd_i,
  input  logic [RET_W-1:0][XLEN-1:0]        ret_wdata_i,
  input  logic                              filter_x0_i,
  input  logic                              flush_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [XLEN-1:0]                   out_pc_o,
  output logic [XLEN-1:0]                   out_instr_o,
  output logic [4:0]                        out_rd_o,
  output logic [XLEN-1:0]                   out_wdata_o,
  output logic [CNT_W-1:0]                  out_seq_o,
  output logic [$clog2(DEPTH):0]            level_o,
  output logic [CNT_W-1:0]                  drop_cnt_o,
  output logic                              overflow_o
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] lvl_t;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [4:0]       rd_mem    [DEPTH];
  logic [XLEN-1:0]  wdata_mem [DEPTH];
  logic [CNT_W-1:0] seq_mem   [DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  lvl_t             level;
  logic [CNT_W-1:0] seq_q, drop_cnt;
  logic             overflow;

  logic [RET_W-1:0] elig;
  lvl_t             slot     [RET_W];
  logic [CNT_W-1:0] lane_seq [RET_W];
  lvl_t             k;
  logic [CNT_W-1:0] nvalid;
  lvl_t             space;
  logic             fits, push, pop, drop;
  logic [CNT_W:0]   dsum;

  // slot[] compacts eligible lanes; lane_seq[] numbers every valid lane
  always_comb begin
    k      = '0;
    nvalid = '0;
    for (int l = 0; l < RET_W; l++) begin
      elig[l]     = ret_valid_i[l] && !(filter_x0_i && ret_rd_i[l] == 5'd0);
      slot[l]     = k;
      lane_seq[l] = seq_q + nvalid;
      k           = k + lvl_t'(elig[l]);
      nvalid      = nvalid + CNT_W'(ret_valid_i[l]);
    end
  end

  // Space is judged on start-of-cycle occupancy; a same-cycle pop frees nothing
  assign space = lvl_t'(DEPTH) - level;
  assign fits  = (k <= space);
  assign pop   = out_valid_o && out_ready_i;
  assign push  = fits && !flush_i && (k != '0);
  assign drop  = !fits && !flush_i;
  assign dsum  = {1'b0, drop_cnt} + (CNT_W+1)'(k);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq_q    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      seq_q <= seq_q + nvalid;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + k[AW-1:0];
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        level <= level + (push ? k : lvl_t'(0)) - (pop ? lvl_t'(1) : lvl_t'(0));
      end
      if (drop) begin
        drop_cnt <= dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < RET_W; l++) begin
      if (push && elig[l]) begin
        pc_mem   [wr_ptr + slot[l][AW-1:0]] <= ret_pc_i[l];
        instr_mem[wr_ptr + slot[l][AW-1:0]] <= ret_instr_i[l];
        rd_mem   [wr_ptr + slot[l][AW-1:0]] <= ret_rd_i[l];
        wdata_mem[wr_ptr + slot[l][AW-1:0]] <= ret_wdata_i[l];
        seq_mem  [wr_ptr + slot[l][AW-1:0]] <= lane_seq[l];
      end
    end
  end

  // Head fields read as zero while empty so reset and idle states are clean
  assign out_valid_o = (level != '0);
  assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr]    : '0;
  assign out_instr_o = out_valid_o ? instr_mem[rd_ptr] : '0;
  assign out_rd_o    = out_valid_o ? rd_mem[rd_ptr]    : '0;
  assign out_wdata_o = (out_valid_o && rd_mem[rd_ptr] != 5'd0) ? wdata_mem[rd_ptr] : '0;
  assign out_seq_o   = out_valid_o ? seq_mem[rd_ptr]   : '0;
  assign level_o     = level;
  assign drop_cnt_o  = drop_cnt;
  assign overflow_o  = overflow;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed table, corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_commit_trace_buffer;
  localparam int RW = 2;
  localparam int DP = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0]         valid;
  logic [RW-1:0][31:0]   pc, instr, wdata;
  logic [RW-1:0][4:0]    rd;
  logic                  filter, flush, ready;
  logic                  out_valid;
  logic [31:0]           out_pc, out_instr, out_wdata;
  logic [4:0]            out_rd;
  logic [CW-1:0]         out_seq, drop_cnt;
  logic [4:0]            level;
  logic                  overflow;

  always #5 clk = ~clk;

  commit_trace_buffer #(.XLEN(32), .RET_W(RW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .ret_valid_i(valid), .ret_pc_i(pc), .ret_instr_i(instr),
    .ret_rd_i(rd), .ret_wdata_i(wdata), .filter_x0_i(filter), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(ready), .out_pc_o(out_pc), .out_instr_o(out_instr),
    .out_rd_o(out_rd), .out_wdata_o(out_wdata), .out_seq_o(out_seq), .level_o(level),
    .drop_cnt_o(drop_cnt), .overflow_o(overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of retired records plus counters
  typedef struct {
    logic [31:0] pc, instr, wdata;
    logic [4:0]  rd;
    logic [7:0]  seq;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] mseq;
  int         mdrop;
  bit         movf;

  task automatic model_update();
    ent_t grp[$];
    int   free_slots;
    bit   popv;
    if (rst) begin
      mq.delete(); mseq = 0; mdrop = 0; movf = 0;
      return;
    end
    popv = (mq.size() != 0) && ready;
    free_slots = DP - mq.size();
    for (int l = 0; l < RW; l++) begin
      if (valid[l]) begin
        if (!(filter && rd[l] == 0))
          grp.push_back('{pc[l], instr[l], (rd[l] == 0) ? 32'h0 : wdata[l], rd[l], mseq});
        mseq = mseq + 8'd1;
      end
    end
    if (flush) begin
      mq.delete();
    end else if (grp.size() > free_slots) begin
      mdrop = (mdrop + grp.size() > 255) ? 255 : mdrop + grp.size();
      movf  = 1;
      if (popv) void'(mq.pop_front());
    end else begin
      if (popv) void'(mq.pop_front());
      foreach (grp[i]) mq.push_back(grp[i]);
    end
  endtask

  task automatic model_check();
    chk("m_valid", out_valid, mq.size() != 0);
    chk("m_level", level, mq.size());
    chk("m_drop", drop_cnt, mdrop);
    chk("m_ovf", overflow, movf);
    if (mq.size() != 0) begin
      chk("m_seq", out_seq, mq[0].seq);
      chk("m_pc", out_pc, mq[0].pc);
      chk("m_instr", out_instr, mq[0].instr);
      chk("m_rd", out_rd, mq[0].rd);
      chk("m_wdata", out_wdata, mq[0].wdata);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle_inputs();
    valid = '0; pc = '0; rd = '0; wdata = '0; filter = 0; flush = 0; ready = 0;
    instr[0] = 32'h00500093; instr[1] = 32'h00000013;
  endtask

  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] pc0, pc1;
    logic [4:0]  rd0, rd1;
    logic [31:0] wd0, wd1;
    logic        filt, rdy, ev;
    logic [4:0]  elvl;
    logic [7:0]  eseq;
    logic [31:0] epc, ewd;
    logic [7:0]  edrop;
  } vec_t;

  vec_t tbl[9];
  int   thr;

  initial begin
    tbl[0] = '{2'b01, 32'h0,  32'h0,  5'd1, 5'd0, 32'h5,  32'h0,  1'b0, 1'b0, 1'b1, 5'd1, 8'd0, 32'h0,  32'h5,  8'd0};
    tbl[1] = '{2'b00, 32'h0,  32'h0,  5'd0, 5'd0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 32'h0,  32'h0,  8'd0};
    tbl[2] = '{2'b11, 32'h4,  32'h8,  5'd2, 5'd3, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1, 5'd2, 8'd1, 32'h4,  32'h11, 8'd0};
    tbl[3] = '{2'b10, 32'h0,  32'hC,  5'd0, 5'd4, 32'h0,  32'h33, 1'b0, 1'b1, 1'b1, 5'd2, 8'd2, 32'h8,  32'h22, 8'd0};
    tbl[4] = '{2'b00, 32'h0,  32'h0,  5'd0, 5'd0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b1, 5'd1, 8'd3, 32'hC,  32'h33, 8'd0};
    tbl[5] = '{2'b00, 32'h0,  32'h0,  5'd0, 5'd0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 32'h0,  32'h0,  8'd0};
    tbl[6] = '{2'b11, 32'h10, 32'h14, 5'd0, 5'd3, 32'h55, 32'h66, 1'b1, 1'b0, 1'b1, 5'd1, 8'd5, 32'h14, 32'h66, 8'd0};
    tbl[7] = '{2'b01, 32'h18, 32'h0,  5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b1, 5'd1, 8'd6, 32'h18, 32'h0, 8'd0};
    tbl[8] = '{2'b00, 32'h0,  32'h0,  5'd0, 5'd0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 32'h0,  32'h0,  8'd0};

    idle_inputs();
    rst = 1;
    step(); step();
    chk("rst_valid", out_valid, 0); chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);   chk("rst_ovf", overflow, 0);
    chk("rst_seq", out_seq, 0);     chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0); chk("rst_rd", out_rd, 0);
    chk("rst_wdata", out_wdata, 0);
    rst = 0;

    foreach (tbl[i]) begin
      valid = tbl[i].v; pc[0] = tbl[i].pc0; pc[1] = tbl[i].pc1;
      rd[0] = tbl[i].rd0; rd[1] = tbl[i].rd1; wdata[0] = tbl[i].wd0; wdata[1] = tbl[i].wd1;
      filter = tbl[i].filt; ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].elvl);
      chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].edrop);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_seq", i), out_seq, tbl[i].eseq);
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_wdata", i), out_wdata, tbl[i].ewd);
      end
    end

    // Fill to 15, then an all-or-nothing drop of a 2-lane group
    idle_inputs();
    for (int i = 0; i < 15; i++) begin
      valid = 2'b01; pc[0] = 32'h100 + 4 * i; rd[0] = 5'd5; wdata[0] = i;
      step();
    end
    chk("fill_level", level, 15); chk("fill_head_seq", out_seq, 7);
    valid = 2'b11; rd[1] = 5'd6;
    step();
    chk("grpdrop_cnt", drop_cnt, 2); chk("grpdrop_ovf", overflow, 1); chk("grpdrop_level", level, 15);
    valid = 2'b01; pc[0] = 32'h200;
    step();
    chk("full_level", level, 16);
    ready = 1;
    step();
    chk("fullpop_level", level, 15); chk("fullpop_drop", drop_cnt, 3); chk("fullpop_head", out_seq, 8);
    valid = 2'b00;
    for (int i = 0; i < 10; i++) step();
    chk("drain_level", level, 5); chk("drain_head", out_seq, 18);
    valid = 2'b11; flush = 1;
    step();
    flush = 0;
    chk("flush_level", level, 0); chk("flush_valid", out_valid, 0); chk("flush_drop", drop_cnt, 3);
    valid = 2'b01; ready = 0; pc[0] = 32'h300;
    step();
    chk("postflush_seq", out_seq, 28); chk("postflush_level", level, 1);
    valid = 2'b00;
    step(); step();
    chk("stall_seq", out_seq, 28); chk("stall_pc", out_pc, 32'h300);

    rst = 1;
    step();
    rst = 0;
    chk("midrst_valid", out_valid, 0); chk("midrst_level", level, 0);
    chk("midrst_drop", drop_cnt, 0);   chk("midrst_ovf", overflow, 0);

    // Random traffic with varying sink bias to exercise fill, drain and saturation
    thr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) thr = (c / 200 % 3 == 0) ? 20 : (c / 200 % 3 == 1) ? 90 : 50;
      valid  = 2'($urandom_range(0, 3));
      filter = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 49) == 0);
      ready  = ($urandom_range(0, 99) < thr);
      for (int l = 0; l < RW; l++) begin
        pc[l] = $urandom; instr[l] = $urandom; wdata[l] = $urandom;
        rd[l] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Multi-lane retire-trace capture buffer for the obsidyen core family. Accepts up to `RET_W` retired instructions per cycle (pc, instruction, destination register, write data), tags each with a retire sequence number, and queues them in order in a `DEPTH`-entry FIFO. The FIFO drains one entry per cycle over a valid/ready port to a trace sink (log writer, UART streamer, debug bus). It replaces the fixed single-lane `pc/instr/reg_addr/reg_data/update` trace with a buffered, back-pressurable, lossy-with-accounting stream usable by pipelined and dual-issue cores.

## Interface
- `XLEN`, 32: datapath width.
- `RET_W`, 2: retire lanes per cycle (1..4); lane 0 is oldest.
- `DEPTH`, 16: FIFO entries; power of two, ≥ `RET_W`.
- `CNT_W`, 32: width of sequence and drop counters.

- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `ret_valid_i`  in  RET_W  per-lane retire strobe; any bit pattern is legal.
- `ret_pc_i`  in  RET_W×XLEN  per-lane pc.
- `ret_instr_i`  in  RET_W×XLEN  per-lane instruction word.
- `ret_rd_i`  in  RET_W×5  per-lane destination register; 0 = no register write.
- `ret_wdata_i`  in  RET_W×XLEN  per-lane write data.
- `filter_x0_i`  in  1  when 1, lanes with `ret_rd_i`==0 are counted in sequence but not queued.
- `flush_i`  in  1  discard all queued entries.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  sink accepts head entry.
- `out_pc_o`, `out_instr_o`  out  XLEN  head pc / instruction.
- `out_rd_o`  out  5  head destination register.
- `out_wdata_o`  out  XLEN  head write data; forced to 0 when `out_rd_o`==0.
- `out_seq_o`  out  CNT_W  retire sequence number of head entry.
- `level_o`  out  $clog2(DEPTH)+1  current occupancy.
- `drop_cnt_o`  out  CNT_W  saturating count of dropped entries.
- `overflow_o`  out  1  sticky; set on first drop, cleared only by reset.

## Operation
- Each cycle the valid lanes form a retire group. The lanes are numbered in ascending order: every valid lane consumes the next sequence number (`seq_q`, `seq_q+1`, …), whether the lane is filtered, queued or dropped. `seq_q` wraps modulo 2^CNT_W.
- Eligible lanes are valid lanes that are not filtered. Let k be their number.
- Space check uses occupancy at cycle start. A pop in the same cycle does not free space for that cycle's push.
- If k ≤ DEPTH − level, all k entries are written at consecutive write-pointer slots in lane order. Gaps left by invalid or filtered lanes are compacted.
- If k > DEPTH − level, the whole group is dropped (all-or-nothing, never partial). `drop_cnt` += k, saturating at 2^CNT_W−1, and `overflow_o` is set.
- Pop: when `out_valid_o` && `out_ready_i`, the head advances. Output fields are driven from the head slot and are stable while valid && !ready.
- `flush_i`: occupancy goes to 0 and pointers realign. A same-cycle push and pop are discarded, and the pushed lanes are not counted as drops. `seq`, `drop_cnt` and `overflow` are unaffected.
- Pointers are log2(DEPTH) bits and wrap naturally. `level` = pushes − pops, and never exceeds DEPTH.

## Timing
- Reset: `out_valid_o`=0, `level_o`=0, `drop_cnt_o`=0, `overflow_o`=0, `out_seq_o`=0, and the other out fields are 0. The next sequence number is 0. A reset mid-stream discards the contents immediately.
- Latency: an entry pushed at edge t is visible on `out_valid_o` after edge t (registered); there is no combinational input→output path.
- Throughput: up to RET_W pushes and 1 pop per cycle. Sustained retire rate > 1/cycle eventually overflows unless the sink is idle-tolerant. This is by design.
- `out_ready_i` can be asserted independently of `out_valid_o`. The sink must not depend combinationally on `out_valid_o` for ready.
- Full (level==DEPTH) with pop and push of k≥1 in the same cycle: the group is dropped and the pop completes, so level becomes DEPTH−1.

## Test plan
- Reset, then single lane 0 valid with pc=0x0, instr=0x00500093, rd=1, wdata=5 → next cycle `out_valid_o`=1 with those fields, `out_seq_o`=0, `level_o`=1. Pop it → level 0.
- RET_W=2, both lanes valid with pc 0x4/0x8 and ready=0 → two entries in order, seq 0 then 1. Only lane 1 valid next → seq 2, with no gap in the FIFO.
- filter_x0_i=1, lanes rd=0 and rd=3 → only the rd=3 entry is queued, carrying seq 1. With filter off, the rd=0 entry is output with wdata=0 even if input wdata=0xDEADBEEF.
- DEPTH=16, ready=0, fill to 15, then push a 2-lane group → the group is dropped, `drop_cnt_o`=2, `overflow_o`=1, level stays 15. A following 1-lane push is accepted (level 16) with seq advanced by 3.
- level=16, pop and 1-lane push in the same cycle → push dropped, level 15, `drop_cnt_o` incremented by 1.
- level=5 with flush_i and a 2-lane push in the same cycle → level 0, `out_valid_o`=0 next cycle, drop count unchanged, next accepted entry's seq is 2 higher than before.
